// File: rtl/tcas_dmsp_pkg.sv
// Shared types and constants for the TCAS DMSP pulse-detection path.
package tcas_dmsp_pkg;

  localparam int SAMPLE_W = 20;
  localparam int MAG_W    = 19;
  localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    OVERLONG = 2'd2,
    HOLDOFF  = 2'd3
  } pd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tcas_abs_sat.sv
// Registered absolute value of a signed FIR sample, saturated to the magnitude width.
module tcas_abs_sat
  import tcas_dmsp_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic        [MAG_W-1:0]    mag
);

  logic [SAMPLE_W-1:0] neg;
  logic                is_most_neg;

  assign neg         = ~din + SAMPLE_W'(1);
  // The most negative code has no positive counterpart; clamp it to full scale.
  assign is_most_neg = (din == {1'b1, {MAG_W{1'b0}}});

  always_ff @(posedge clk) begin
    if (reset) begin
      mag <= '0;
    end else if (is_most_neg) begin
      mag <= MAG_MAX;
    end else if (din[SAMPLE_W-1]) begin
      mag <= neg[MAG_W-1:0];
    end else begin
      mag <= din[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/tcas_pulse_detector.sv
// Hysteresis pulse detector on rectified FIR output; emits start/width/peak per qualified pulse.
module tcas_pulse_detector
  import tcas_dmsp_pkg::*;
#(
  parameter int MIN_W = 6,
  parameter int MAX_W = 16,
  parameter int HOLD  = 4,
  parameter int TSW   = 32,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] data_input,
  input  logic        [MAG_W-1:0]    thr_on,
  input  logic        [MAG_W-1:0]    thr_off,
  output logic                       pulse_valid,
  output logic        [TSW-1:0]      pulse_start,
  output logic        [CW-1:0]       pulse_width,
  output logic        [MAG_W-1:0]    pulse_peak,
  output logic        [15:0]         reject_cnt,
  output logic                       busy
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  pd_state_t         state, state_n;
  logic [TSW-1:0]    ts, ts_d;
  logic [MAG_W-1:0]  mag;
  logic [MAG_W-1:0]  thr_off_q, thr_off_n;
  logic [TSW-1:0]    start_q, start_n;
  logic [CW-1:0]     width_q, width_n;
  logic [MAG_W-1:0]  peak_q, peak_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic              valid_n;
  logic [TSW-1:0]    out_start_n;
  logic [CW-1:0]     out_width_n;
  logic [MAG_W-1:0]  out_peak_n;
  logic [15:0]       reject_n;

  tcas_abs_sat u_abs_sat (
    .clk   (clk),
    .reset (reset),
    .din   (data_input),
    .mag   (mag)
  );

  // ts_d pairs each magnitude with the timestamp of the sample it came from.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts   <= '0;
      ts_d <= '0;
    end else begin
      ts   <= ts + TSW'(1);
      ts_d <= ts;
    end
  end

  always_comb begin
    state_n     = state;
    thr_off_n   = thr_off_q;
    start_n     = start_q;
    width_n     = width_q;
    peak_n      = peak_q;
    hold_n      = hold_cnt;
    valid_n     = 1'b0;
    out_start_n = pulse_start;
    out_width_n = pulse_width;
    out_peak_n  = pulse_peak;
    reject_n    = reject_cnt;
    unique case (state)
      IDLE: begin
        if (mag >= thr_on) begin
          state_n   = ACTIVE;
          thr_off_n = thr_off;
          start_n   = ts_d;
          width_n   = CW'(1);
          peak_n    = mag;
        end
      end
      ACTIVE: begin
        if (mag > thr_off_q) begin
          if (width_q >= CW'(MAX_W)) begin
            state_n  = OVERLONG;
            reject_n = sat_inc16(reject_cnt);
          end else begin
            width_n = width_q + CW'(1);
            if (mag > peak_q) peak_n = mag;
          end
        end else begin
          if (width_q >= CW'(MIN_W)) begin
            valid_n     = 1'b1;
            out_start_n = start_q;
            out_width_n = width_q;
            out_peak_n  = peak_q;
          end else begin
            reject_n = sat_inc16(reject_cnt);
          end
          if (HOLD == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            hold_n  = HW'(HOLD - 1);
          end
        end
      end
      OVERLONG: begin
        if (mag <= thr_off_q) begin
          if (HOLD == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            hold_n  = HW'(HOLD - 1);
          end
        end
      end
      HOLDOFF: begin
        if (hold_cnt == '0) state_n = IDLE;
        else                hold_n  = hold_cnt - HW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      thr_off_q   <= '0;
      start_q     <= '0;
      width_q     <= '0;
      peak_q      <= '0;
      hold_cnt    <= '0;
      pulse_valid <= 1'b0;
      pulse_start <= '0;
      pulse_width <= '0;
      pulse_peak  <= '0;
      reject_cnt  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      thr_off_q   <= thr_off_n;
      start_q     <= start_n;
      width_q     <= width_n;
      peak_q      <= peak_n;
      hold_cnt    <= hold_n;
      pulse_valid <= valid_n;
      pulse_start <= out_start_n;
      pulse_width <= out_width_n;
      pulse_peak  <= out_peak_n;
      reject_cnt  <= reject_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule
